comp_writeback: RTL and testbench
=================================

# comp_writeback

Completion write-back stage directly downstream of the AES/SHA completion queue. Pops one destination address per completion from the queue's valid/ready output and issues a single status-token write to that address on the control memory bus. Handles bus errors and timeouts with bounded retry, counts completions, and raises a one-cycle interrupt per successful write-back.

## Interface
- ADDRW, 24, completion/destination address width (matches queue entry width)
- DATAW, 8, bus write-data width
- DONE_TOKEN, 8'hA5, value written to each destination address
- TIMEOUT, 63, max cycles in REQ without ack before counting an attempt failure
- MAX_RETRY, 3, extra attempts after first failure before dropping the entry

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  queue has an entry (queue valid_out)
- in_addr  in  ADDRW  entry address (queue data_out)
- in_ready  out  1  block accepts an entry this cycle (to queue ready_in)
- bus_req  out  1  write request, held until ack/err/timeout
- bus_addr  out  ADDRW  write address, stable while bus_req=1
- bus_wdata  out  DATAW  DONE_TOKEN while bus_req=1, else 0
- bus_ack  in  1  write completed, sampled only while bus_req=1
- bus_err  in  1  write failed, sampled only while bus_req=1
- irq  out  1  one-cycle pulse per successful write-back
- done_count  out  16  successful write-backs, wraps 16'hFFFF→0
- err_sticky  out  1  set when an entry is dropped
- err_addr  out  ADDRW  address of most recently dropped entry
- err_clear  in  1  synchronous clear of err_sticky

## Operation
- States: IDLE, REQ, BACKOFF. All outputs registered except in_ready = (state==IDLE).
- IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch in_addr into bus_addr, clear retry and timeout counters, go REQ.
- REQ: bus_req=1, bus_wdata=DONE_TOKEN. Timeout counter increments each cycle in REQ.
  - bus_ack=1: done_count+1, irq=1 next cycle, go IDLE.
  - else bus_err=1, or timeout counter reaches TIMEOUT: attempt failure.
- Attempt failure: if retry < MAX_RETRY: retry+1, go BACKOFF. Else: err_sticky=1, err_addr=bus_addr, go IDLE (entry dropped, no irq, done_count unchanged).
- BACKOFF: bus_req=0 for exactly 2 cycles, timeout counter cleared, then REQ with same bus_addr.
- Priority in same cycle: bus_ack over bus_err over timeout. err_sticky set over err_clear.
- bus_ack/bus_err ignored outside REQ. in_valid ignored outside IDLE (entry stays in queue).
- Reset values: state IDLE, bus_req 0, bus_addr 0, bus_wdata 0, irq 0, done_count 0, err_sticky 0, err_addr 0, counters 0; in_ready 1 out of reset. Reset mid-REQ abandons the in-flight entry with no irq.

## Timing
- Accept at edge T → bus_req=1 in cycle T+1.
- Ack sampled at edge E → bus_req=0, irq=1, in_ready=1 in cycle E+1; irq low at E+2 unless another ack.
- Throughput: one entry per 2 cycles with same-cycle ack (accept edge, ack edge, accept edge ...).
- Timeout: with no response, failure declared at the edge where REQ has lasted TIMEOUT+1 cycles.
- Worst-case occupancy per entry: (MAX_RETRY+1)·(TIMEOUT+1) + 2·MAX_RETRY cycles.
- err_clear takes effect on the next edge.

## Test plan
- Single entry, addr 24'h00_1234, ack in first REQ cycle → one bus write addr 24'h001234 data 8'hA5, irq one cycle, done_count=1.
- Four back-to-back queue entries, ack always 1 → writes in order, one per 2 cycles, done_count=4, four irq pulses.
- bus_err on first two attempts, ack on third → bus_req low exactly 2 cycles between attempts, done_count=1, err_sticky=0.
- No response ever, addr 24'hABCDEF → 4 attempts of 64 cycles each, then err_sticky=1, err_addr=24'hABCDEF, done_count=0, next entry accepted.
- bus_ack and bus_err both high in same REQ cycle → treated as success; err_clear with simultaneous drop → err_sticky stays 1.
- rst_n asserted mid-REQ → all outputs to reset values immediately; after release, next entry processed normally, done_count counts from 0.

Source files
------------

// File: rtl/comp_writeback.sv
//------------------------------------------------------------------------------
// Module   : comp_writeback
// Purpose  : Pops completion addresses and writes a status token to each,
//            retrying failed or timed-out writes with a bounded backoff.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module comp_writeback #(
  parameter int               ADDRW      = 24,
  parameter int               DATAW      = 8,
  parameter logic [DATAW-1:0] DONE_TOKEN = 8'hA5,
  parameter int               TIMEOUT    = 63,
  parameter int               MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ADDRW-1:0] in_addr,
  output logic             in_ready,
  output logic             bus_req,
  output logic [ADDRW-1:0] bus_addr,
  output logic [DATAW-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic             bus_err,
  output logic             irq,
  output logic [15:0]      done_count,
  output logic             err_sticky,
  output logic [ADDRW-1:0] err_addr,
  input  logic             err_clear
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] c_timeout   = TW'(TIMEOUT);
  localparam logic [RW-1:0] c_max_retry = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_BACKOFF = 2'd2
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tcnt;
  logic [RW-1:0]    r_retry;
  logic             r_bcnt;
  logic             r_bus_req;
  logic [ADDRW-1:0] r_bus_addr;
  logic [DATAW-1:0] r_bus_wdata;
  logic             r_irq;
  logic [15:0]      r_done_count;
  logic             r_err_sticky;
  logic [ADDRW-1:0] r_err_addr;

  assign in_ready   = (r_state == S_IDLE);
  assign bus_req    = r_bus_req;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign irq        = r_irq;
  assign done_count = r_done_count;
  assign err_sticky = r_err_sticky;
  assign err_addr   = r_err_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tcnt       <= '0;
      r_retry      <= '0;
      r_bcnt       <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_irq        <= 1'b0;
      r_done_count <= '0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      r_irq <= 1'b0;
      // A drop later in this block overrides the clear.
      if (err_clear) begin
        r_err_sticky <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bus_addr  <= in_addr;
            r_retry     <= '0;
            r_tcnt      <= '0;
            r_bus_req   <= 1'b1;
            r_bus_wdata <= DONE_TOKEN;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_done_count <= r_done_count + 16'd1;
            r_irq        <= 1'b1;
            r_bus_req    <= 1'b0;
            r_bus_wdata  <= '0;
            r_state      <= S_IDLE;
          end else if (bus_err || (r_tcnt == c_timeout)) begin
            r_bus_req   <= 1'b0;
            r_bus_wdata <= '0;
            r_tcnt      <= '0;
            if (r_retry < c_max_retry) begin
              r_retry <= r_retry + 1'b1;
              r_bcnt  <= 1'b0;
              r_state <= S_BACKOFF;
            end else begin
              r_err_sticky <= 1'b1;
              r_err_addr   <= r_bus_addr;
              r_state      <= S_IDLE;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_BACKOFF: begin
          r_tcnt <= '0;
          if (r_bcnt) begin
            r_bus_req   <= 1'b1;
            r_bus_wdata <= DONE_TOKEN;
            r_state     <= S_REQ;
          end else begin
            r_bcnt <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_comp_writeback.sv
//------------------------------------------------------------------------------
// Module   : tb_comp_writeback
// Purpose  : Directed self-checking bench for comp_writeback.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_comp_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_addr = '0;
  logic        in_ready;
  logic        bus_req;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic        irq;
  logic [15:0] done_count;
  logic        err_sticky;
  logic [23:0] err_addr;
  logic        err_clear = 1'b0;

  int tests = 0;
  int fails = 0;

  comp_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_ready   (in_ready),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err),
    .irq        (irq),
    .done_count (done_count),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then observed and inputs set 1ns later.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step;
    step;
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (bus_wdata !== 8'h00) begin fails++; $display("FAIL reset_wdata: got %h expected 00", bus_wdata); end
    tests++; if (done_count !== 16'd0) begin fails++; $display("FAIL reset_done: got %0d expected 0", done_count); end
    tests++; if ({irq, err_sticky} !== 2'b00) begin fails++; $display("FAIL reset_irq_err: got %b expected 00", {irq, err_sticky}); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_addr = 24'h001234;
    step;
    in_valid = 1'b0;
    tests++; if ({bus_req, in_ready} !== 2'b10) begin fails++; $display("FAIL single_req: got %b expected 10", {bus_req, in_ready}); end
    tests++; if (bus_addr !== 24'h001234) begin fails++; $display("FAIL single_addr: got %h expected 001234", bus_addr); end
    tests++; if (bus_wdata !== 8'hA5) begin fails++; $display("FAIL single_wdata: got %h expected a5", bus_wdata); end
    bus_ack = 1'b1;
    step;
    bus_ack = 1'b0;
    tests++; if ({bus_req, irq, in_ready} !== 3'b011) begin fails++; $display("FAIL single_ack: got %b expected 011", {bus_req, irq, in_ready}); end
    tests++; if (done_count !== 16'd1) begin fails++; $display("FAIL single_done: got %0d expected 1", done_count); end
    step;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL single_irq_low: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] addrs [4];
    int pulses = 0;
    addrs[0] = 24'h100000; addrs[1] = 24'h200001; addrs[2] = 24'h300002; addrs[3] = 24'h400003;
    bus_ack = 1'b1;
    in_valid = 1'b1; in_addr = addrs[0];
    for (int i = 0; i < 4; i++) begin
      step;
      tests++; if ({bus_req, bus_addr} !== {1'b1, addrs[i]}) begin fails++; $display("FAIL b2b_write%0d: got %b/%h expected 1/%h", i, bus_req, bus_addr, addrs[i]); end
      in_valid = (i < 3);
      if (i < 3) in_addr = addrs[i+1];
      step;
      if (irq === 1'b1 && bus_req === 1'b0) pulses++;
    end
    in_valid = 1'b0;
    step;
    bus_ack = 1'b0;
    tests++; if (pulses !== 4) begin fails++; $display("FAIL b2b_irq_pulses: got %0d expected 4", pulses); end
    tests++; if (done_count !== 16'd5) begin fails++; $display("FAIL b2b_done: got %0d expected 5", done_count); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL b2b_irq_low: got %b expected 0", irq); end
  endtask

  task automatic test_retry;
    int low;
    in_valid = 1'b1; in_addr = 24'h000055;
    step;
    in_valid = 1'b0;
    for (int a = 0; a < 3; a++) begin
      tests++; if ({bus_req, bus_addr} !== {1'b1, 24'h000055}) begin fails++; $display("FAIL retry_req%0d: got %b/%h expected 1/000055", a, bus_req, bus_addr); end
      if (a < 2) bus_err = 1'b1; else bus_ack = 1'b1;
      step;
      bus_err = 1'b0; bus_ack = 1'b0;
      if (a < 2) begin
        low = 0;
        while (bus_req === 1'b0 && low < 10) begin
          low++;
          step;
        end
        tests++; if (low !== 2) begin fails++; $display("FAIL retry_backoff%0d: got %0d cycles expected 2", a, low); end
      end
    end
    tests++; if ({irq, err_sticky} !== 2'b10) begin fails++; $display("FAIL retry_end: got %b expected 10", {irq, err_sticky}); end
    tests++; if (done_count !== 16'd6) begin fails++; $display("FAIL retry_done: got %0d expected 6", done_count); end
    step;
  endtask

  task automatic test_timeout;
    int n;
    int low;
    int irqs = 0;
    in_valid = 1'b1; in_addr = 24'hABCDEF;
    step;
    in_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      n = 0;
      while (bus_req === 1'b1 && n < 200) begin
        n++;
        step;
        if (irq === 1'b1) irqs++;
      end
      tests++; if (n !== 64) begin fails++; $display("FAIL timeout_attempt%0d: got %0d cycles expected 64", a, n); end
      if (a < 3) begin
        low = 0;
        while (bus_req === 1'b0 && low < 10) begin
          low++;
          step;
        end
        tests++; if (low !== 2) begin fails++; $display("FAIL timeout_backoff%0d: got %0d cycles expected 2", a, low); end
      end
    end
    tests++; if ({err_sticky, in_ready, irqs != 0} !== 3'b110) begin fails++; $display("FAIL timeout_drop: got %b expected 110", {err_sticky, in_ready, irqs != 0}); end
    tests++; if (err_addr !== 24'hABCDEF) begin fails++; $display("FAIL timeout_err_addr: got %h expected abcdef", err_addr); end
    tests++; if (done_count !== 16'd6) begin fails++; $display("FAIL timeout_done: got %0d expected 6", done_count); end
    in_valid = 1'b1; in_addr = 24'h000777;
    step;
    in_valid = 1'b0;
    tests++; if ({bus_req, bus_addr} !== {1'b1, 24'h000777}) begin fails++; $display("FAIL timeout_next: got %b/%h expected 1/000777", bus_req, bus_addr); end
    bus_ack = 1'b1;
    step;
    bus_ack = 1'b0;
    tests++; if (done_count !== 16'd7) begin fails++; $display("FAIL timeout_next_done: got %0d expected 7", done_count); end
  endtask

  task automatic test_priority;
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL prio_clear: got %b expected 0", err_sticky); end
    in_valid = 1'b1; in_addr = 24'h000888;
    step;
    in_valid = 1'b0;
    bus_ack = 1'b1; bus_err = 1'b1;
    step;
    bus_ack = 1'b0; bus_err = 1'b0;
    tests++; if ({irq, bus_req, err_sticky} !== 3'b100) begin fails++; $display("FAIL prio_ack_err: got %b expected 100", {irq, bus_req, err_sticky}); end
    tests++; if (done_count !== 16'd8) begin fails++; $display("FAIL prio_done: got %0d expected 8", done_count); end
    in_valid = 1'b1; in_addr = 24'h000999;
    step;
    in_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_err = 1'b1;
      err_clear = (a == 3);
      step;
      bus_err = 1'b0; err_clear = 1'b0;
      if (a < 3) begin
        step;
        step;
      end
    end
    tests++; if ({err_sticky, in_ready} !== 2'b11) begin fails++; $display("FAIL prio_set_over_clear: got %b expected 11", {err_sticky, in_ready}); end
    tests++; if (err_addr !== 24'h000999) begin fails++; $display("FAIL prio_err_addr: got %h expected 000999", err_addr); end
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL prio_clear2: got %b expected 0", err_sticky); end
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_addr = 24'h000ABC;
    step;
    in_valid = 1'b0;
    tests++; if (bus_req !== 1'b1) begin fails++; $display("FAIL rstmid_req: got %b expected 1", bus_req); end
    rst_n = 1'b0;
    #1;
    tests++; if ({bus_req, irq, in_ready} !== 3'b001) begin fails++; $display("FAIL rstmid_ctrl: got %b expected 001", {bus_req, irq, in_ready}); end
    tests++; if ({bus_addr, bus_wdata, done_count} !== 48'h0) begin fails++; $display("FAIL rstmid_data: got %h expected 0", {bus_addr, bus_wdata, done_count}); end
    step;
    rst_n = 1'b1;
    in_valid = 1'b1; in_addr = 24'h000DEF;
    step;
    in_valid = 1'b0;
    tests++; if ({bus_req, bus_addr} !== {1'b1, 24'h000DEF}) begin fails++; $display("FAIL rstmid_next: got %b/%h expected 1/000def", bus_req, bus_addr); end
    bus_ack = 1'b1;
    step;
    bus_ack = 1'b0;
    tests++; if ({irq, done_count} !== {1'b1, 16'd1}) begin fails++; $display("FAIL rstmid_done: got %b/%0d expected 1/1", irq, done_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_retry;
    test_timeout;
    test_priority;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
